// File: rtl/lbist_pkg.sv
// Shared types and constants for the LBIST pattern generator / signature register.
// Default polynomials are tap masks for the left-shifting LFSR in lbist_lfsr_step.
package lbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_PRPG = 1'b0;
    localparam logic MODE_MISR = 1'b1;

    // Bit i set feeds r[i] into the feedback XOR.
    localparam logic [3:0]  POLY_W4  = 4'b1100;
    localparam logic [15:0] POLY_W16 = 16'hB400;
    localparam logic [19:0] POLY_W20 = 20'h9_0000;
    localparam logic [31:0] POLY_W32 = 32'h8020_0003;

endpackage

// File: rtl/lbist_lfsr_step.sv
// Combinational next-value function: one LFSR shift, optionally folding in a
// response word for MISR compaction.
module lbist_lfsr_step #(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h8020_0003)
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] data_in,
    input  logic             mode,
    output logic [WIDTH-1:0] next
);
    import lbist_pkg::*;

    logic             fb;
    logic [WIDTH-1:0] step;

    always_comb begin
        fb   = ^(r & TAPS);
        step = {r[WIDTH-2:0], fb};
        next = (mode == MODE_MISR) ? (step ^ data_in) : step;
    end

endmodule

// File: rtl/lbist_prpg.sv
// LBIST pattern generator / MISR with IDLE-RUN-DONE sequencing and a step counter.
// All outputs are flops; status outputs are registered copies of the next state.
module lbist_prpg #(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h8020_0003),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int unsigned      CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             start,
    input  logic [CNT_W-1:0] n_patterns,
    input  logic             abort,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy,
    output logic             done
);
    import lbist_pkg::*;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   next_val;

    lbist_lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .r       (r_q),
        .data_in (data_in),
        .mode    (mode_q),
        .next    (next_val)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (seed_load) begin
                    r_d = seed_in;
                end
                if (start) begin
                    mode_d  = mode;
                    cnt_d   = n_patterns;
                    state_d = (n_patterns == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over expiry and freezes the register where it is.
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (mode_q == MODE_PRPG && r_q == '0) begin
                        r_d = SEED;
                    end else begin
                        r_d = next_val;
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_RUN);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= SEED;
            cnt_q   <= '0;
            mode_q  <= MODE_PRPG;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dout  = r_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_lbist_prpg.sv
// Scoreboard bench for lbist_prpg (WIDTH=4): driver queues expected outputs from
// an arithmetic reference model, an independent monitor pops and compares them.
module tb_lbist_prpg;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 16;
    localparam logic [3:0]  TP = 4'b1100;
    localparam logic [3:0]  SD = 4'h1;

    logic          clk;
    logic          rst_n;
    logic          mode;
    logic          seed_load;
    logic [W-1:0]  seed_in;
    logic          start;
    logic [CW-1:0] n_patterns;
    logic          abort;
    logic [W-1:0]  data_in;
    logic [W-1:0]  dout;
    logic          valid;
    logic          busy;
    logic          done;

    lbist_prpg #(
        .WIDTH (W),
        .TAPS  (TP),
        .SEED  (SD),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .start      (start),
        .n_patterns (n_patterns),
        .abort      (abort),
        .data_in    (data_in),
        .dout       (dout),
        .valid      (valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        logic [3:0] val;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] model_r;
    logic [3:0] dat [0:63];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: shift left by one (times two, mod 16), append parity of tapped bits.
    function automatic logic [3:0] model_next(input logic [3:0] r, input logic [3:0] d, input bit misr);
        logic [3:0] taps;
        int         par;
        int         v;
        taps = TP;
        par  = 0;
        for (int b = 0; b < 4; b++) begin
            if (taps[b] && r[b]) par = par ^ 1;
        end
        v = ((int'(r) * 2) % 16) + par;
        if (misr) return 4'(v) ^ d;
        if (r == 4'h0) return SD;
        return 4'(v);
    endfunction

    always @(negedge clk) begin
        if (rst_n && (valid || done)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {30'b0, valid, done}, 32'h0);
            end else begin
                mon_e = q.pop_front();
                chk(mon_e.is_done ? "done_kind" : "valid_kind", {30'b0, valid, done},
                    mon_e.is_done ? 32'h1 : 32'h2);
                chk(mon_e.is_done ? "done_dout" : "valid_dout", 32'(dout), 32'(mon_e.val));
                if (valid) chk("busy_on_valid", 32'(busy), 32'h1);
            end
        end
    end

    task automatic run_case(input string name, input bit md, input int n, input bit ld,
                            input logic [3:0] sv, input int abort_at);
        logic [3:0] mr;
        exp_t       e;
        int         cycles;
        mr = ld ? sv : model_r;
        for (int i = 0; i < n; i++) begin
            e.is_done = 1'b0;
            e.val     = mr;
            q.push_back(e);
            if (abort_at != 0 && i == abort_at - 1) break;
            mr = model_next(mr, dat[i], md);
        end
        if (abort_at == 0) begin
            e.is_done = 1'b1;
            e.val     = mr;
            q.push_back(e);
        end
        @(negedge clk);
        start      = 1'b1;
        mode       = md;
        n_patterns = CW'(n);
        seed_load  = ld;
        seed_in    = sv;
        abort      = 1'b0;
        cycles     = (abort_at != 0) ? abort_at : n;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            // Control inputs other than abort/data_in must be ignored while busy.
            start      = 1'($urandom);
            seed_load  = 1'($urandom);
            seed_in    = 4'($urandom);
            mode       = 1'($urandom);
            n_patterns = CW'($urandom);
            data_in    = dat[i];
            abort      = (abort_at != 0 && i == abort_at - 1);
        end
        @(negedge clk);
        start     = 1'b0;
        seed_load = 1'b0;
        if (abort_at != 0) begin
            abort = 1'b0;
            chk({name, "_abort_busy"}, 32'(busy), 32'h0);
            chk({name, "_abort_dout"}, 32'(dout), 32'(mr));
        end else begin
            abort = 1'($urandom);
        end
        model_r = mr;
        for (int k = 0; k < 4 && q.size() != 0; k++) @(negedge clk);
        abort = 1'b0;
        chk({name, "_drain"}, 32'(q.size()), 32'h0);
        chk({name, "_idle_busy"}, 32'(busy), 32'h0);
        chk({name, "_final"}, 32'(dout), 32'(mr));
    endtask

    initial begin
        logic [3:0] mr;
        exp_t       e;
        int         n;
        int         ab;

        rst_n = 1'b0; mode = 1'b0; seed_load = 1'b0; seed_in = '0; start = 1'b0;
        n_patterns = '0; abort = 1'b0; data_in = '0;
        for (int i = 0; i < 64; i++) dat[i] = 4'h0;
        #12;
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_dout", 32'(dout), 32'(SD));
        @(negedge clk);
        rst_n   = 1'b1;
        model_r = SD;

        @(negedge clk); seed_load = 1'b1; seed_in = 4'h7;
        @(negedge clk); seed_load = 1'b0;
        chk("seed_load_idle", 32'(dout), 32'h7);
        model_r = 4'h7;

        run_case("prpg6", 1'b0, 6, 1'b1, 4'h1, 0);
        chk("prpg6_const", 32'(dout), 32'hD);
        run_case("prpg15", 1'b0, 15, 1'b1, 4'h1, 0);
        chk("prpg15_period", 32'(dout), 32'h1);
        run_case("n0", 1'b0, 0, 1'b0, 4'h0, 0);
        run_case("lockup", 1'b0, 2, 1'b1, 4'h0, 0);
        chk("lockup_const", 32'(dout), 32'h2);

        dat[0] = 4'hA; dat[1] = 4'h5;
        run_case("misr2", 1'b1, 2, 1'b1, 4'h0, 0);
        for (int i = 0; i < 64; i++) dat[i] = 4'($urandom);
        run_case("abort3", 1'b0, 10, 1'b1, 4'h1, 3);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 64; i++) dat[i] = 4'($urandom);
            n  = int'($urandom_range(0, 20));
            ab = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
            run_case("rand", 1'($urandom), n, 1'($urandom), 4'($urandom_range(0, 15)), ab);
        end

        // Asynchronous reset between edges in the middle of a run.
        mr = 4'h5;
        for (int i = 0; i < 4; i++) begin
            e.is_done = 1'b0;
            e.val     = mr;
            q.push_back(e);
            mr = model_next(mr, 4'h0, 1'b0);
        end
        @(negedge clk);
        start = 1'b1; mode = 1'b0; n_patterns = CW'(10); seed_load = 1'b1; seed_in = 4'h5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0; seed_load = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(valid), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_dout", 32'(dout), 32'(SD));
        chk("midrst_drain", 32'(q.size()), 32'h0);
        q.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        model_r = SD;
        run_case("post_reset", 1'b0, 3, 1'b0, 4'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
